receiver: RTL and testbench

8N1 UART receiver: the receive-side counterpart of the team's ready/valid UART transmitter. It runs on the same 16x-oversampled peripheral clock, so one bit period is 16 `clk` cycles. It synchronizes the serial line, detects and validates the start bit, samples 8 data bits LSB-first at mid-bit, and checks the stop bit. Each good byte is presented to the host through a one-entry ready/valid holding buffer, with framing-error and overrun flags.

---
 rtl/receiver.sv | 132 +++++++++++++
 tb/tb_receiver.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/receiver.sv
// 8N1 UART receiver, 16 clocks per bit, with a one-entry ready/valid
// holding buffer and framing-error / overrun pulses.
module receiver (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_serial_in,
   input  logic       rx_data_ready,
   output logic [7:0] rx_data,
   output logic       rx_data_valid,
   output logic       rx_framing_err,
   output logic       rx_overrun
);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [2:0] idx_q, idx_d;
   logic [7:0] shift_q, shift_d;
   logic [7:0] data_q, data_d;
   logic       valid_q, valid_d;
   logic       fe_q, fe_d;
   logic       ov_q, ov_d;
   logic       meta_q, sync_q;
   logic       deliver;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = valid_q;
      fe_d    = 1'b0;
      ov_d    = 1'b0;
      deliver = 1'b0;

      if (valid_q && rx_data_ready)
         valid_d = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (!sync_q)
               state_d = START;
         end
         START: begin
            if (cnt_q == 4'd7) begin
               idx_d   = 3'd0;
               state_d = sync_q ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt_q == 4'd15) begin
               shift_d[idx_q] = sync_q;
               idx_d = idx_q + 3'd1;
               if (idx_q == 3'd7)
                  state_d = STOP;
            end
         end
         STOP: begin
            if (cnt_q == 4'd15) begin
               if (sync_q) begin
                  deliver = 1'b1;
                  state_d = IDLE;
               end else begin
                  fe_d    = 1'b1;
                  state_d = WAIT_HIGH;
               end
            end
         end
         WAIT_HIGH: begin
            if (sync_q)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // A draining buffer frees its slot on the same edge the new byte lands
      if (deliver) begin
         if (!valid_q || rx_data_ready) begin
            data_d  = shift_q;
            valid_d = 1'b1;
         end else begin
            ov_d = 1'b1;
         end
      end

      if (state_d != state_q)
         cnt_d = 4'd0;
      else if (state_q == START || state_q == DATA || state_q == STOP)
         cnt_d = cnt_q + 4'd1;
      else
         cnt_d = 4'd0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q  <= 1'b1;
         sync_q  <= 1'b1;
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         idx_q   <= 3'd0;
         shift_q <= 8'h00;
         data_q  <= 8'h00;
         valid_q <= 1'b0;
         fe_q    <= 1'b0;
         ov_q    <= 1'b0;
      end else begin
         meta_q  <= rx_serial_in;
         sync_q  <= meta_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         fe_q    <= fe_d;
         ov_q    <= ov_d;
      end
   end

   assign rx_data        = data_q;
   assign rx_data_valid  = valid_q;
   assign rx_framing_err = fe_q;
   assign rx_overrun     = ov_q;

endmodule

// File: tb/tb_receiver.sv
// Scoreboard bench for the 8N1 receiver: bytes are queued when sent
// and popped when the host side sees a valid/ready transfer.
module tb_receiver;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_serial_in = 1'b1;
   logic       rx_data_ready = 1'b0;
   logic [7:0] rx_data;
   logic       rx_data_valid;
   logic       rx_framing_err;
   logic       rx_overrun;

   receiver dut (
      .clk            (clk),
      .rst            (rst),
      .rx_serial_in   (rx_serial_in),
      .rx_data_ready  (rx_data_ready),
      .rx_data        (rx_data),
      .rx_data_valid  (rx_data_valid),
      .rx_framing_err (rx_framing_err),
      .rx_overrun     (rx_overrun)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int last_fall = 0;
   int rise_cyc = 0;
   int fe_cyc = 0;
   int ov_cyc = 0;
   int fe_cnt = 0;
   int ov_cnt = 0;
   int xfer_cnt = 0;
   logic prev_valid = 1'b0;
   logic [7:0] exp_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (rx_framing_err) begin
            fe_cnt++;
            fe_cyc = cyc;
         end
         if (rx_overrun) begin
            ov_cnt++;
            ov_cyc = cyc;
         end
         if (rx_data_valid && !prev_valid)
            rise_cyc = cyc;
         if (rx_data_valid && rx_data_ready) begin
            xfer_cnt++;
            if (exp_q.size() == 0)
               chk("spurious_byte", exp_q.size(), 1);
            else
               chk("rx_data", rx_data, exp_q.pop_front());
         end
      end
      prev_valid = rx_data_valid;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b, input logic stop);
      rx_serial_in = 1'b0;
      last_fall = cyc;
      repeat (16) step();
      for (int i = 0; i < 8; i++) begin
         rx_serial_in = b[i];
         repeat (16) step();
      end
      rx_serial_in = stop;
      repeat (16) step();
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 400 && exp_q.size() > 0; i++)
         step();
      chk(tag, exp_q.size(), 0);
   endtask

   int fe0, ov0, x0, t0;
   logic [7:0] b2b [4];

   initial begin
      b2b[0] = 8'h00;
      b2b[1] = 8'hFF;
      b2b[2] = 8'h55;
      b2b[3] = 8'h3C;

      repeat (3) step();
      chk("rst_valid", rx_data_valid, 0);
      chk("rst_data", rx_data, 8'h00);
      chk("rst_fe", rx_framing_err, 0);
      chk("rst_ov", rx_overrun, 0);
      rst = 1'b0;
      step();

      // single byte, host not ready
      exp_q.push_back(8'hA5);
      send(8'hA5, 1'b1);
      chk("latency", rise_cyc - last_fall, 155);
      chk("single_valid", rx_data_valid, 1);
      chk("single_data", rx_data, 8'hA5);
      repeat (50) step();
      chk("single_stable", rx_data, 8'hA5);
      rx_data_ready = 1'b1;
      step();
      rx_data_ready = 1'b0;
      chk("single_drop_valid", rx_data_valid, 0);

      // back-to-back frames, host always ready
      fe0 = fe_cnt; ov0 = ov_cnt; x0 = xfer_cnt;
      rx_data_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(b2b[i]);
         send(b2b[i], 1'b1);
      end
      drain("b2b_drain");
      chk("b2b_xfers", xfer_cnt - x0, 4);
      chk("b2b_fe", fe_cnt - fe0, 0);
      chk("b2b_ov", ov_cnt - ov0, 0);

      // short low glitch is a false start
      x0 = xfer_cnt;
      rx_serial_in = 1'b0;
      repeat (4) step();
      rx_serial_in = 1'b1;
      repeat (40) step();
      chk("glitch_valid", rx_data_valid, 0);
      chk("glitch_xfer", xfer_cnt - x0, 0);
      chk("glitch_flags", (fe_cnt - fe0) + (ov_cnt - ov0), 0);
      exp_q.push_back(8'h81);
      send(8'h81, 1'b1);
      drain("glitch_next");

      // framing error followed by a held-low line
      x0 = xfer_cnt;
      send(8'h42, 1'b0);
      repeat (40) step();
      rx_serial_in = 1'b1;
      repeat (20) step();
      chk("fe_count", fe_cnt - fe0, 1);
      chk("fe_time", fe_cyc - last_fall, 155);
      chk("fe_no_xfer", xfer_cnt - x0, 0);
      chk("fe_valid", rx_data_valid, 0);
      exp_q.push_back(8'h42);
      send(8'h42, 1'b1);
      drain("fe_next");
      chk("fe_after", fe_cnt - fe0, 1);

      // overrun
      rx_data_ready = 1'b0;
      exp_q.push_back(8'h11);
      send(8'h11, 1'b1);
      send(8'h22, 1'b1);
      repeat (5) step();
      chk("ov_count", ov_cnt - ov0, 1);
      chk("ov_time", ov_cyc - last_fall, 155);
      chk("ov_valid", rx_data_valid, 1);
      chk("ov_data", rx_data, 8'h11);
      rx_data_ready = 1'b1;
      step();
      rx_data_ready = 1'b0;
      chk("ov_drop_valid", rx_data_valid, 0);
      chk("ov_queue", exp_q.size(), 0);

      // ready lands exactly on the delivery edge
      exp_q.push_back(8'h11);
      exp_q.push_back(8'h22);
      send(8'h11, 1'b1);
      t0 = cyc;
      fork
         send(8'h22, 1'b1);
         begin
            while (cyc < t0 + 154) step();
            rx_data_ready = 1'b1;
            step();
            rx_data_ready = 1'b0;
         end
      join
      chk("bnd_ov", ov_cnt - ov0, 1);
      chk("bnd_valid", rx_data_valid, 1);
      chk("bnd_data", rx_data, 8'h22);
      rx_data_ready = 1'b1;
      step();
      rx_data_ready = 1'b0;
      chk("bnd_queue", exp_q.size(), 0);

      // reset in the middle of data bit 4, with a byte buffered
      send(8'h5A, 1'b1);
      rx_serial_in = 1'b0;
      repeat (16) step();
      for (int i = 0; i < 4; i++) begin
         rx_serial_in = i[0];
         repeat (16) step();
      end
      rx_serial_in = 1'b1;
      repeat (8) step();
      rst = 1'b1;
      repeat (3) step();
      chk("mid_rst_valid", rx_data_valid, 0);
      chk("mid_rst_data", rx_data, 8'h00);
      chk("mid_rst_fe", rx_framing_err, 0);
      chk("mid_rst_ov", rx_overrun, 0);
      rst = 1'b0;
      step();
      fe0 = fe_cnt; ov0 = ov_cnt;
      rx_data_ready = 1'b1;
      exp_q.push_back(8'h99);
      send(8'h99, 1'b1);
      drain("post_rst");
      chk("post_rst_flags", (fe_cnt - fe0) + (ov_cnt - ov0), 0);

      repeat (5) step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
